// File: rtl/wave_capture_if.sv
// Bundles the sample stream, display-idle status and RAM write port of wave_capture.
// Latency: not applicable, this file only holds wires.
// Backpressure: none. The sample stream is strobe-only, with no ready signal.
interface wave_capture_if #(
    parameter int SAMPLE_W = 16
);
    logic                new_sample_ready;
    logic [SAMPLE_W-1:0] new_sample_in;
    logic                wave_display_idle;
    logic [8:0]          write_address;
    logic                write_enable;
    logic [7:0]          write_sample;
    logic                read_index;

    // Capture side: consumes the samples and drives the RAM write port.
    modport master (
        input  new_sample_ready,
        input  new_sample_in,
        input  wave_display_idle,
        output write_address,
        output write_enable,
        output write_sample,
        output read_index
    );

    // Environment side: drives the samples and observes the writes and the active half.
    modport slave (
        output new_sample_ready,
        output new_sample_in,
        output wave_display_idle,
        input  write_address,
        input  write_enable,
        input  write_sample,
        input  read_index
    );
endinterface

// File: rtl/wave_capture.sv
// Captures a 256-sample frame into the display RAM half not being read, starting at a rising zero crossing.
// Latency: the write port is registered and is valid one cycle after the accepted strobe.
// Backpressure: none. Every strobe is handled at full rate, and strobes outside a capture are ignored.
module wave_capture #(
    parameter int SAMPLE_W = 16   // must match the interface parameter; >= 8
) (
    input  logic           clk,
    input  logic           reset,
    wave_capture_if.master bus
);
    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] count, count_nxt;
    logic       prev_neg;
    logic       read_index_q, read_index_nxt;
    logic       we_q, we_nxt;
    logic [8:0] addr_q, addr_nxt;
    logic [7:0] sample_q, sample_nxt;

    logic       sample_neg;
    logic       crossing;
    logic [7:0] sample_ob;

    assign sample_neg = bus.new_sample_in[SAMPLE_W-1];
    // A crossing uses prev_neg before this strobe updates it. A zero sample counts as non-negative.
    assign crossing   = bus.new_sample_ready & prev_neg & ~sample_neg;
    // Keep the top 8 bits and flip the sign bit, giving offset binary for the display.
    assign sample_ob  = {~sample_neg, bus.new_sample_in[SAMPLE_W-2:SAMPLE_W-8]};

    // Register the state, the frame counter and all outputs. Reset abandons any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_ARMED;
            count        <= 8'd0;
            read_index_q <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 9'h000;
            sample_q     <= 8'h00;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            read_index_q <= read_index_nxt;
            we_q         <= we_nxt;
            addr_q       <= addr_nxt;
            sample_q     <= sample_nxt;
        end
    end

    // Track the sign of the last strobed sample in every state. It resets to 0, so the first sample cannot trigger.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_neg <= 1'b0;
        end else if (bus.new_sample_ready) begin
            prev_neg <= sample_neg;
        end
    end

    // Compute the next state and the next register values. Writes always target the half the display is not reading.
    always_comb begin
        state_nxt      = state;
        count_nxt      = count;
        read_index_nxt = read_index_q;
        we_nxt         = 1'b0;
        addr_nxt       = addr_q;
        sample_nxt     = sample_q;
        unique case (state)
            ST_ARMED: begin
                if (crossing) begin
                    we_nxt     = 1'b1;
                    addr_nxt   = {~read_index_q, 8'h00};
                    sample_nxt = sample_ob;
                    count_nxt  = 8'd1;
                    state_nxt  = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (bus.new_sample_ready) begin
                    we_nxt     = 1'b1;
                    addr_nxt   = {~read_index_q, count};
                    sample_nxt = sample_ob;
                    count_nxt  = count + 8'd1;
                    if (count == 8'hFF) begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Swap halves only while the display is not drawing.
                if (bus.wave_display_idle) begin
                    read_index_nxt = ~read_index_q;
                    state_nxt      = ST_ARMED;
                end
            end
            default: begin
                state_nxt = ST_ARMED;
            end
        endcase
    end

    assign bus.write_enable  = we_q;
    assign bus.write_address = addr_q;
    assign bus.write_sample  = sample_q;
    assign bus.read_index    = read_index_q;
endmodule

// File: tb/tb_wave_capture.sv
module tb_wave_capture;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    wave_capture_if #(.SAMPLE_W(16)) ifc ();

    wave_capture #(.SAMPLE_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one sample for exactly one rising edge. Outputs are settled when this returns.
    task automatic strobe(input logic [15:0] v);
        @(negedge clk);
        ifc.new_sample_ready = 1'b1;
        ifc.new_sample_in    = v;
        @(posedge clk);
        #1;
        ifc.new_sample_ready = 1'b0;
    endtask

    task automatic check_wr(input string tag, input logic en, input logic [8:0] a, input logic [7:0] s);
        chk({tag, "_we"}, {31'd0, ifc.write_enable}, {31'd0, en});
        chk({tag, "_addr"}, {23'd0, ifc.write_address}, {23'd0, a});
        chk({tag, "_smp"}, {24'd0, ifc.write_sample}, {24'd0, s});
    endtask

    initial begin
        ifc.new_sample_ready  = 1'b0;
        ifc.new_sample_in     = 16'h0000;
        ifc.wave_display_idle = 1'b0;

        // Reset held low while a crossing pattern is strobed.
        strobe(16'hFF9C);
        strobe(16'h0032);
        check_wr("rst_low", 1'b0, 9'h000, 8'h00);
        chk("rst_low_ri", {31'd0, ifc.read_index}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_wr("rst_rel", 1'b0, 9'h000, 8'h00);
        chk("rst_rel_ri", {31'd0, ifc.read_index}, 32'd0);

        // prev_neg resets to 0, so a positive first sample is no crossing.
        strobe(16'h0005);
        chk("first_pos_we", {31'd0, ifc.write_enable}, 32'd0);
        strobe(16'h8000);
        chk("neg8000_we", {31'd0, ifc.write_enable}, 32'd0);
        strobe(16'hFF9C);
        chk("neg100_we", {31'd0, ifc.write_enable}, 32'd0);
        strobe(16'h0032);
        check_wr("cross1", 1'b1, 9'h100, 8'h80);

        // Fill the rest of the frame at full rate.
        for (int i = 1; i < 256; i++) begin
            strobe(16'h7F00);
            check_wr("fill", 1'b1, 9'h100 + 9'(i), 8'hFF);
        end
        // The 257th strobe gives no write, and the write port holds its last values.
        strobe(16'h7F00);
        check_wr("s257", 1'b0, 9'h1FF, 8'hFF);

        // In WAIT, the display is busy for 1000 cycles. Strobes there must not write.
        strobe(16'hFFFF);
        chk("wait_neg_we", {31'd0, ifc.write_enable}, 32'd0);
        strobe(16'h0000);
        chk("wait_cross_we", {31'd0, ifc.write_enable}, 32'd0);
        repeat (1000) @(posedge clk);
        #1;
        chk("wait_ri", {31'd0, ifc.read_index}, 32'd0);
        strobe(16'hFFFF);
        // Raise idle together with a zero sample. The swap happens, but this strobe cannot trigger.
        @(negedge clk);
        ifc.wave_display_idle = 1'b1;
        ifc.new_sample_ready  = 1'b1;
        ifc.new_sample_in     = 16'h0000;
        @(posedge clk);
        #1;
        ifc.new_sample_ready  = 1'b0;
        ifc.wave_display_idle = 1'b0;
        chk("swap_ri", {31'd0, ifc.read_index}, 32'd1);
        chk("swap_we", {31'd0, ifc.write_enable}, 32'd0);
        strobe(16'h0000);
        chk("after_swap_we", {31'd0, ifc.write_enable}, 32'd0);
        strobe(16'hFFFF);
        chk("arm2_neg_we", {31'd0, ifc.write_enable}, 32'd0);
        strobe(16'h0000);
        check_wr("cross2", 1'b1, 9'h000, 8'h80);

        // Continue to 100 writes in this frame, then reset in the middle of it.
        for (int i = 1; i < 100; i++) begin
            strobe(16'h0100);
        end
        check_wr("frame2_100", 1'b1, 9'h063, 8'h81);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_we", {31'd0, ifc.write_enable}, 32'd0);
        chk("midrst_ri", {31'd0, ifc.read_index}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_hold_we", {31'd0, ifc.write_enable}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // These samples never rise from negative to non-negative.
        strobe(16'd10);
        chk("seq10_we", {31'd0, ifc.write_enable}, 32'd0);
        strobe(16'd20);
        chk("seq20_we", {31'd0, ifc.write_enable}, 32'd0);
        strobe(16'hFFFB);
        chk("seqm5_we", {31'd0, ifc.write_enable}, 32'd0);
        strobe(16'hFFFA);
        chk("seqm6_we", {31'd0, ifc.write_enable}, 32'd0);
        strobe(16'hFFF9);
        chk("seqm7_we", {31'd0, ifc.write_enable}, 32'd0);

        // The new frame starts at count 0 in half 1.
        strobe(16'hFFFF);
        chk("post_rst_neg_we", {31'd0, ifc.write_enable}, 32'd0);
        strobe(16'h0000);
        check_wr("cross3", 1'b1, 9'h100, 8'h80);
        strobe(16'h8000);
        check_wr("cross3_next", 1'b1, 9'h101, 8'h00);
        @(posedge clk);
        #1;
        check_wr("idle_hold", 1'b0, 9'h101, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
